// File: rtl/instr_fetch_pkg.sv
// Shared instruction package for the fetch stage.
// Holds the 9-bit instruction layout (opcode [8:4], register/math/function
// field [3:0]), the opcode and function codes, the fetch state enum and
// the "func, dne" halt instruction constant.
package instr_fetch_pkg;

    localparam int INSTR_W = 9;
    localparam int OPC_W   = 5;
    localparam int FLD_W   = 4;

    // Opcode codes (upper five bits)
    localparam logic [OPC_W-1:0] OPC_NOP  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_LOAD = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_MATH = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_JUMP = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_FUNC = 5'b11111;

    // Function codes used with OPC_FUNC
    localparam logic [FLD_W-1:0] FN_NOP = 4'b0000;
    localparam logic [FLD_W-1:0] FN_DNE = 4'b1111;

    // "func, dne": stops fetching when it is handed to decode
    localparam logic [INSTR_W-1:0] HALT_INSTR = {OPC_FUNC, FN_DNE};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr == HALT_INSTR;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
//   imem_addr/imem_req  : read request, data returns on imem_data one cycle later
//   out_instr/out_pc    : instruction offered to decode, with out_valid/out_ready
//   redirect_valid/_pc  : jump/branch target coming back from downstream
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both high; once out_valid is high, out_instr/out_pc hold
// until that transfer (or a redirect/halt/reset flush).
// modport master = fetch side, modport slave = memory/decode side.
interface instr_fetch_if #(parameter int PC_W = 10);
    import instr_fetch_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic               imem_req;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_valid;
    logic               out_ready;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;

    modport master (
        output imem_addr, imem_req, out_instr, out_pc, out_valid,
        input  imem_data, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, imem_req, out_instr, out_pc, out_valid,
        output imem_data, out_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry fall-through instruction buffer.
//   push/din    : write an entry (ignored when flush is high)
//   pop         : consume the head (only meaningful while valid)
//   flush       : drop every entry, wins over push and pop
//   dout/valid  : head entry; when empty, a pushed word appears on dout the
//                 same cycle so a read can reach decode without a bubble
//   full/empty  : stored-entry status (the fall-through word is not counted)
module fetch_fifo #(parameter int W = 19) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         store;
    logic         drop;

    always_comb begin
        empty = (count == 2'd0);
        full  = (count == 2'd2);
        valid = !empty || push;
        dout  = empty ? (push ? din : '0) : mem[rd_ptr];
        // A word that falls through and is popped in the same cycle is never stored.
        store = push && !(empty && pop);
        drop  = pop && !empty;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (drop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, store} - {1'b0, drop};
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues sequential reads to instruction memory,
// buffers up to two returned instructions and hands them to decode in order.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   start/start_pc : in IDLE or HALT, begin fetching at start_pc
//   bus            : instr_fetch_if.master (memory, decode and redirect signals)
//   halted         : fetch stopped on the "func, dne" instruction
//   state_dbg      : current fetch state, for observation
// Build option: define FETCH_HALT_DETECT_EN to stop fetching when the halt
// instruction is handed to decode; without it that word is an ordinary
// instruction, HALT is never entered and halted stays 0.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_pc,
    instr_fetch_if.master    bus,
    output logic             halted,
    output fetch_state_e     state_dbg
);

    localparam int ENT_W = PC_W + INSTR_W;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [PC_W-1:0] tag_q, tag_d;       // address of the read in flight
    logic            imem_req;
    logic            push, pop, flush, halt_hit;
    logic [ENT_W-1:0] fifo_dout;
    logic            fifo_valid, fifo_full, fifo_empty;

    fetch_fifo #(.W(ENT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({tag_q, bus.imem_data}),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Request only while stored + in-flight < 2, so a returning read always
    // finds room. Deliberately independent of out_ready.
    always_comb begin
        imem_req = (state_q == RUN) && !fifo_full && (fifo_empty || !inflight_q);
        push     = inflight_q;
        pop      = fifo_valid && bus.out_ready;
`ifdef FETCH_HALT_DETECT_EN
        halt_hit = (state_q == RUN) && pop && is_halt(fifo_dout[INSTR_W-1:0]);
`else
        halt_hit = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        flush      = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                // redirect_valid is ignored here; start alone restarts fetch
                if (start) begin
                    state_d = RUN;
                    pc_d    = start_pc;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    // Flush also discards this cycle's returning word and kills
                    // the read issued this cycle (inflight_d stays 0).
                    flush = 1'b1;
                    pc_d  = bus.redirect_pc;
                end else if (halt_hit) begin
                    state_d = HALT;
                    flush   = 1'b1;
                end else if (imem_req) begin
                    inflight_d = 1'b1;
                    tag_d      = pc_q;
                    pc_d       = pc_q + PC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    always_comb begin
        bus.imem_addr = pc_q;
        bus.imem_req  = imem_req;
        bus.out_valid = fifo_valid;
        bus.out_pc    = fifo_dout[ENT_W-1:INSTR_W];
        bus.out_instr = fifo_dout[INSTR_W-1:0];
        state_dbg     = state_q;
`ifdef FETCH_HALT_DETECT_EN
        halted        = (state_q == HALT);
`else
        halted        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. The reference model is a queue of
// expected PCs (sequential from the last start/redirect target); each
// transfer must match the queue head and the memory image at that PC.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int PC_W  = 10;
    localparam int DEPTH = 1 << PC_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] start_pc;
    logic            halted;
    fetch_state_e    state_dbg;

    instr_fetch_if #(.PC_W(PC_W)) bus ();

    instr_fetch #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_pc  (start_pc),
        .bus       (bus),
        .halted    (halted),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Instruction memory: data valid the cycle after a request, junk otherwise
    logic [INSTR_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_data <= mem[bus.imem_addr];
        else              bus.imem_data <= INSTR_W'($urandom);
    end

    int checks = 0;
    int errors = 0;
    logic [PC_W-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; start_pc = '0;
        bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic load_exp(input logic [PC_W-1:0] first);
        logic [PC_W-1:0] p;
        p = first;
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(p);
            p = p + PC_W'(1);
        end
    endtask

    task automatic do_start(input logic [PC_W-1:0] pc);
        start = 1'b1; start_pc = pc;
        next_cycle();
        start = 1'b0;
        load_exp(pc);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < DEPTH; i++) mem[i] = INSTR_W'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = INSTR_W'($urandom_range(0, 510));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0 || halted !== 1'b0 ||
            bus.out_instr !== '0 || bus.out_pc !== '0 || bus.imem_addr !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs valid=%b req=%b halted=%b instr=%h pc=%h addr=%h, all required 0",
                     bus.out_valid, bus.imem_req, halted, bus.out_instr, bus.out_pc, bus.imem_addr);
        end
        checks++;
        if (state_dbg !== IDLE) begin
            errors++; $display("FAIL reset_state got %0d required %0d", state_dbg, IDLE);
        end
        next_cycle();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h155;
        next_cycle();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.imem_addr !== '0 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL idle_redirect req=%b valid=%b addr=%h state=%0d required 0/0/000/IDLE",
                     bus.imem_req, bus.out_valid, bus.imem_addr, state_dbg);
        end
    endtask

    task automatic test_basic();
        logic [PC_W-1:0] e;
        do_reset(); fill_ramp(); bus.out_ready = 1'b1;
        do_start(10'h010);
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h010 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_first_req req=%b addr=%h valid=%b required 1/010/0",
                     bus.imem_req, bus.imem_addr, bus.out_valid);
        end
        next_cycle();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL basic_throughput cycle %0d valid=%b required 1", c, bus.out_valid);
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL basic_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        logic [PC_W-1:0] e;
        do_reset(); fill_random(); bus.out_ready = 1'b1;
        do_start(PC_W'($urandom_range(0, DEPTH-1)));
        @(negedge clk); next_cycle();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL stall_pre_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            next_cycle();
        end
        for (int c = 0; c < 5; c++) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_q[0] || bus.out_instr !== mem[exp_q[0]]) begin
                errors++; $display("FAIL stall_hold valid=%b pc=%h instr=%h required 1 pc=%h instr=%h",
                                   bus.out_valid, bus.out_pc, bus.out_instr, exp_q[0], mem[exp_q[0]]);
            end
            if (c >= 1) begin
                checks++;
                if (bus.imem_req !== 1'b0) begin
                    errors++; $display("FAIL stall_req cycle %0d req=%b required 0", c, bus.imem_req);
                end
            end
            next_cycle();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL stall_post_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect();
        logic [PC_W-1:0] e, tgt;
        do_reset(); fill_random(); bus.out_ready = 1'b1;
        do_start(PC_W'($urandom_range(0, 200)));
        @(negedge clk); next_cycle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL redir_pre_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            next_cycle();
        end
        bus.out_ready = 1'b0;
        repeat (3) next_cycle();          // buffer fills with two entries
        bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h200;
        next_cycle();
        bus.redirect_valid = 1'b0; load_exp(10'h200);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h200) begin
            errors++; $display("FAIL redir_flush valid=%b req=%b addr=%h required 0/1/200",
                               bus.out_valid, bus.imem_req, bus.imem_addr);
        end
        next_cycle();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL redir_valid cycle %0d valid=%b required 1", c, bus.out_valid);
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL redir_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            next_cycle();
        end
        // Redirect while a transfer-ready stream is flowing
        tgt = PC_W'($urandom_range(0, DEPTH-1));
        bus.redirect_valid = 1'b1; bus.redirect_pc = tgt;
        next_cycle();
        bus.redirect_valid = 1'b0; load_exp(tgt);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL redir2_flush valid=%b required 0", bus.out_valid);
        end
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL redir2_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] e;
        do_reset(); fill_random(); bus.out_ready = 1'b1;
        // start and redirect together in IDLE: start wins
        start = 1'b1; start_pc = 10'h3FE; bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h100;
        next_cycle();
        start = 1'b0; bus.redirect_valid = 1'b0; load_exp(10'h3FE);
        @(negedge clk);
        checks++;
        if (bus.imem_addr !== 10'h3FE || bus.imem_req !== 1'b1) begin
            errors++; $display("FAIL wrap_start addr=%h req=%b required 3fe/1", bus.imem_addr, bus.imem_req);
        end
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL wrap_valid cycle %0d valid=%b required 1", c, bus.out_valid);
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL wrap_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_halt();
        logic [PC_W-1:0] e;
        logic seen, got6;
        seen = 1'b0; got6 = 1'b0;
        do_reset(); fill_random(); mem[5] = HALT_INSTR; bus.out_ready = 1'b1;
        do_start(10'h002);
        @(negedge clk); next_cycle();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (seen) begin
                checks++;
                if (halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin
                    errors++; $display("FAIL halt_stop halted=%b req=%b valid=%b required 1/0/0",
                                       halted, bus.imem_req, bus.out_valid);
                end
            end else begin
                checks++;
                if (halted !== 1'b0) begin
                    errors++; $display("FAIL halt_early halted=%b required 0", halted);
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++; e = exp_q.pop_front();
                    if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                        errors++; $display("FAIL halt_xfer pc=%h instr=%h required pc=%h instr=%h",
                                           bus.out_pc, bus.out_instr, e, mem[e]);
                    end
`ifdef FETCH_HALT_DETECT_EN
                    if (e == 10'h005) seen = 1'b1;
`endif
                    if (e == 10'h006) got6 = 1'b1;
                end
            end
            next_cycle();
        end
`ifdef FETCH_HALT_DETECT_EN
        checks++;
        if (!seen) begin
            errors++; $display("FAIL halt_missing seen=%b required 1", seen);
        end
        do_start(10'h030);
        @(negedge clk); next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (halted !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL halt_resume halted=%b valid=%b required 0/1", halted, bus.out_valid);
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL halt_resume_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            next_cycle();
        end
`else
        checks++;
        if (!got6) begin
            errors++; $display("FAIL halt_passthrough reached_006=%b required 1", got6);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [PC_W-1:0] e;
        do_reset(); fill_random(); bus.out_ready = 1'b1;
        do_start(PC_W'($urandom_range(0, DEPTH-1)));
        @(negedge clk); next_cycle();
        for (int c = 0; c < 8; c++) begin
            bus.out_ready = (c >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL rstmid_pre_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            next_cycle();
        end
        rst_n = 1'b0;                    // one edge, with a read in flight
        next_cycle();
        rst_n = 1'b1; exp_q.delete();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0 || halted !== 1'b0 ||
            bus.out_instr !== '0 || bus.out_pc !== '0 || bus.imem_addr !== '0 || state_dbg !== IDLE)
        begin
            errors++;
            $display("FAIL rstmid_outputs valid=%b req=%b halted=%b instr=%h pc=%h addr=%h state=%0d required zeros/IDLE",
                     bus.out_valid, bus.imem_req, halted, bus.out_instr, bus.out_pc, bus.imem_addr, state_dbg);
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
                errors++; $display("FAIL rstmid_stale valid=%b req=%b required 0/0", bus.out_valid, bus.imem_req);
            end
        end
        next_cycle();
        do_start(PC_W'($urandom_range(0, DEPTH-1)));
        @(negedge clk); next_cycle();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL rstmid_post_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic [PC_W-1:0] e;
        logic redir, prev_stall;
        prev_stall = 1'b0;
        do_reset(); fill_random();
        do_start(PC_W'($urandom_range(0, DEPTH-1)));
        @(negedge clk); next_cycle();
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 19) == 0);
            bus.redirect_valid = redir;
            if (redir) bus.redirect_pc = PC_W'($urandom);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_q[0] || bus.out_instr !== mem[exp_q[0]]) begin
                    errors++; $display("FAIL rand_hold valid=%b pc=%h instr=%h required 1 pc=%h instr=%h",
                                       bus.out_valid, bus.out_pc, bus.out_instr, exp_q[0], mem[exp_q[0]]);
                end
            end
            if (redir) begin
                load_exp(bus.redirect_pc);
            end else if (bus.out_valid && bus.out_ready) begin
                checks++; e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e]) begin
                    errors++; $display("FAIL rand_xfer pc=%h instr=%h required pc=%h instr=%h",
                                       bus.out_pc, bus.out_instr, e, mem[e]);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready && !redir;
            next_cycle();
        end
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 10, instruction-memory address width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  in IDLE or HALT, begin fetching at start_pc.
REQ-005 SHALL have port start_pc  input  PC_W  first fetch address.
REQ-006 SHALL have port imem_addr  output  PC_W  instruction-memory read address.
REQ-007 SHALL have port imem_req  output  1  read issued this cycle.
REQ-008 SHALL have port imem_data  input  9  read data, valid exactly one cycle after imem_req.
REQ-009 SHALL have port out_instr  output  9  instruction to decode: opcode [8:4], register/math/function field [3:0].
REQ-010 SHALL have port out_pc  output  PC_W  address of out_instr.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1)  decode handshake; transfer when both high.
REQ-012 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, PC_W)  jump/branch target from downstream.
REQ-013 SHALL have port halted  output  1  fetch stopped on the done instruction.

Function
REQ-014 SHALL implement states IDLE, RUN, HALT; IDLE->RUN and HALT->RUN on start; RUN->HALT on accepting the halt instruction.
REQ-015 SHALL load PC=start_pc on the start edge; first imem_req in the following cycle; first out_valid two cycles after the start edge.
REQ-016 SHALL hold a 2-entry instruction buffer plus at most one read in flight; imem_req high in RUN only when buffered + in-flight < 2.
REQ-017 SHALL, per issued read, increment PC by 1 modulo 2^PC_W (wrap from all-ones to 0 without flag).
REQ-018 SHALL push returned imem_data with its PC into the buffer the cycle it arrives unless killed.
REQ-019 SHALL present the buffer head on out_instr/out_pc with out_valid = buffer non-empty; pop on transfer; FIFO order.
REQ-020 SHALL keep out_instr/out_pc stable while out_valid high and out_ready low; no combinational path from out_ready to imem_req; out_ready low never loses an instruction.
REQ-021 SHALL, at a redirect_valid edge in RUN, flush the buffer, kill the in-flight read, set PC=redirect_pc; out_valid low next cycle; first redirected instruction out_valid two cycles after.
REQ-022 SHALL give redirect priority over simultaneous push, pop and halt detection.
REQ-023 SHALL ignore redirect_valid in IDLE and HALT.
REQ-024 SHALL, when 9'b11111_1111 (func, dne) transfers in RUN, enter HALT: flush buffer, kill in-flight read, imem_req low, halted high.
REQ-025 SHALL, with start and redirect_valid both high in IDLE/HALT, honour start only.
REQ-026 SHALL sustain one instruction per cycle in steady state with out_ready held high.

Reset
REQ-027 SHALL, at a rst_n-low edge, set state=IDLE, PC=0, buffer empty, in-flight cleared; out_valid=0, imem_req=0, halted=0, out_instr=0, out_pc=0, imem_addr=0.
REQ-028 SHALL discard any read in flight across reset; mid-operation reset leaves no stale instruction.

Configuration
REQ-029 SHALL compile halt detection only when FETCH_HALT_DETECT_EN is defined; undefined: 9'b11111_1111 passes as a normal instruction, HALT unreachable, halted tied 0.

Structure
REQ-030 SHALL place the fetch state enum and the HALT_INSTR constant (9'b11111_1111) in the shared instruction package beside the opcode and function codes.
REQ-031 SHALL implement the buffer as sub-module fetch_fifo (2-entry, parameterised width, push/pop/flush, full/empty).

Verification
REQ-032 SHALL test: reset, start_pc=0x010, out_ready=1, memory[i]=i[8:0] -> out_pc 0x010,0x011,0x012 on consecutive cycles, first out_valid two cycles after start.
REQ-033 SHALL test: out_ready low 5 cycles mid-stream -> out_instr held, imem_req low once 2 outstanding, no instruction lost or duplicated after release.
REQ-034 SHALL test: redirect_valid with redirect_pc=0x200 while buffer full -> buffered entries dropped, next transferred out_pc=0x200.
REQ-035 SHALL test: PC_W=10, start_pc=0x3FE -> out_pc sequence 0x3FE,0x3FF,0x000.
REQ-036 SHALL test: 9'b11111_1111 at 0x005 -> halted=1 after its transfer, no further imem_req; start then resumes; with FETCH_HALT_DETECT_EN undefined fetch continues to 0x006.
REQ-037 SHALL test: rst_n low for one edge mid-stream -> all outputs zero next cycle; stale in-flight data never appears.
